// File: rtl/matvec_pkg.sv
// Shared types and default sizes for the matrix-vector sequencer.
package matvec_pkg;

   localparam int unsigned MATVEC_DATA_W = 8;
   localparam int unsigned MATVEC_ACC_W  = 20;
   localparam int unsigned MATVEC_MAX_L  = 8;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DRAIN,
      OUTPUT,
      DONE
   } MatvecState_t;

endpackage

// File: rtl/matvec_mac.sv
// Multiply-accumulate for one row dot product.
// MATVEC_SAT_EN selects saturating accumulation; otherwise the sum wraps.
module matvec_mac
   import matvec_pkg::*;
#(
   parameter int unsigned DATA_W = MATVEC_DATA_W,
   parameter int unsigned ACC_W  = MATVEC_ACC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_first,
   input  logic              acc_en,
   input  logic [DATA_W-1:0] mat_data,
   input  logic [DATA_W-1:0] vec_data,
   output logic [ACC_W-1:0]  acc
);

   localparam int unsigned PROD_W = 2 * DATA_W;

   logic [PROD_W-1:0] prod;
   logic [ACC_W-1:0]  prod_ext;
   logic [ACC_W-1:0]  acc_next;

   assign prod     = PROD_W'(mat_data) * PROD_W'(vec_data);
   assign prod_ext = ACC_W'(prod);

`ifdef MATVEC_SAT_EN
   logic [ACC_W:0] sum;

   // A carry out clamps to all-ones; a clamped value stays clamped until the next row load.
   always_comb begin
      sum      = '0;
      acc_next = '0;
      sum      = (ACC_W + 1)'(acc) + (ACC_W + 1)'(prod_ext);
      acc_next = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
   end
`else
   always_comb begin
      acc_next = '0;
      acc_next = acc + prod_ext;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc <= '0;
      end else if (acc_en) begin
         acc <= load_first ? prod_ext : acc_next;
      end
   end

endmodule

// File: rtl/matvec_sequencer.sv
// Reads an LxL matrix and an L-vector from RAM and emits one dot product per row on a valid/ready port.
// Define MATVEC_SAT_EN for a saturating accumulator (see matvec_mac).
module matvec_sequencer
   import matvec_pkg::*;
#(
   parameter int unsigned DATA_W = MATVEC_DATA_W,
   parameter int unsigned ACC_W  = MATVEC_ACC_W,
   parameter int unsigned MAX_L  = MATVEC_MAX_L,
   parameter int unsigned IDX_W  = $clog2(MAX_L),
   parameter int unsigned ADDR_W = $clog2(MAX_L * MAX_L)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start_i,
   input  logic [IDX_W:0]    length_i,
   output logic              rd_en_o,
   output logic [ADDR_W-1:0] mat_addr_o,
   output logic [IDX_W-1:0]  vec_addr_o,
   input  logic [DATA_W-1:0] mat_data_i,
   input  logic [DATA_W-1:0] vec_data_i,
   output logic [ACC_W-1:0]  res_data_o,
   output logic [IDX_W-1:0]  res_row_o,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              err_o
);

   localparam int unsigned LEN_W = IDX_W + 1;

   MatvecState_t      state, state_next;
   logic [LEN_W-1:0]  len, len_next;
   logic [IDX_W-1:0]  row, row_next;
   logic [IDX_W-1:0]  col, col_next;
   logic              last_col, last_row, len_ok;

   logic              rd_en_next, res_valid_next, busy_next, done_next, err_next;
   logic [ADDR_W-1:0] mat_addr_next;
   logic [IDX_W-1:0]  vec_addr_next, res_row_next;

   // Read data arrives one cycle after the strobe, so the MAC controls trail the FETCH state by one cycle.
   logic              mac_acc_en, mac_load_first;

   assign last_col = (LEN_W'(col) == (len - LEN_W'(1)));
   assign last_row = (LEN_W'(row) == (len - LEN_W'(1)));
   assign len_ok   = (length_i != '0) && (length_i <= LEN_W'(MAX_L));

   // Next state, counters, and next values of the registered outputs.
   always_comb begin
      state_next = state;
      len_next   = len;
      row_next   = row;
      col_next   = col;
      err_next   = 1'b0;

      case (state)
         IDLE: begin
            if (start_i) begin
               if (len_ok) begin
                  len_next   = length_i;
                  row_next   = '0;
                  col_next   = '0;
                  state_next = FETCH;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         FETCH: begin
            if (last_col) begin
               col_next   = '0;
               state_next = DRAIN;
            end else begin
               col_next = col + IDX_W'(1);
            end
         end
         DRAIN: begin
            state_next = OUTPUT;
         end
         OUTPUT: begin
            if (res_ready_i) begin
               if (last_row) begin
                  state_next = DONE;
               end else begin
                  row_next   = row + IDX_W'(1);
                  col_next   = '0;
                  state_next = FETCH;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase

      rd_en_next     = (state_next == FETCH);
      mat_addr_next  = rd_en_next ?
                       ADDR_W'(ADDR_W'(row_next) * ADDR_W'(len_next) + ADDR_W'(col_next)) : '0;
      vec_addr_next  = rd_en_next ? col_next : '0;
      res_valid_next = (state_next == OUTPUT);
      res_row_next   = res_valid_next ? row_next : '0;
      busy_next      = (state_next != IDLE);
      done_next      = (state_next == DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state          <= IDLE;
         len            <= '0;
         row            <= '0;
         col            <= '0;
         rd_en_o        <= 1'b0;
         mat_addr_o     <= '0;
         vec_addr_o     <= '0;
         res_row_o      <= '0;
         res_valid_o    <= 1'b0;
         busy_o         <= 1'b0;
         done_o         <= 1'b0;
         err_o          <= 1'b0;
         mac_acc_en     <= 1'b0;
         mac_load_first <= 1'b0;
      end else begin
         state          <= state_next;
         len            <= len_next;
         row            <= row_next;
         col            <= col_next;
         rd_en_o        <= rd_en_next;
         mat_addr_o     <= mat_addr_next;
         vec_addr_o     <= vec_addr_next;
         res_row_o      <= res_row_next;
         res_valid_o    <= res_valid_next;
         busy_o         <= busy_next;
         done_o         <= done_next;
         err_o          <= err_next;
         mac_acc_en     <= (state == FETCH);
         mac_load_first <= (state == FETCH) && (col == '0);
      end
   end

   // The accumulator register is the result register; it is idle while OUTPUT waits.
   matvec_mac #(
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk        (clk),
      .reset      (reset),
      .load_first (mac_load_first),
      .acc_en     (mac_acc_en),
      .mat_data   (mat_data_i),
      .vec_data   (vec_data_i),
      .acc        (res_data_o)
   );

endmodule
